// File: rtl/return_addr_stack.sv
// Circular return-address stack: pushes CALL_PC+4 on calls, pops on returns, frozen while a cache stalls.
// Optional macro RAS_OVERWRITE_EN: a push into a full stack overwrites the oldest entry instead of being dropped.
module return_addr_stack #(
  parameter int ADDR_WIDTH  = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic                  CALL,
  input  logic [ADDR_WIDTH-1:0] CALL_PC,
  input  logic                  RET,
  input  logic                  FLUSH,
  output logic                  RETURN,
  output logic [ADDR_WIDTH-1:0] RETURN_ADDR,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int P = $clog2(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [P-1:0]          tos_q, tos_d;
  logic [P:0]            count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  en;
  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  wr_en;
  logic [P-1:0]          wr_idx;
  logic [ADDR_WIDTH-1:0] link;

  assign en    = CACHE_READY & CACHE_READY_DATA;
  assign full  = (count_q == (P+1)'(STACK_DEPTH));
  assign empty = (count_q == '0);
  // The +4 lives on the write side so the read path is a bare mux.
  assign link  = CALL_PC + ADDR_WIDTH'(4);

  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    do_push = 1'b0;
    if (en) begin
      if (FLUSH) begin
        tos_d   = '0;
        count_d = '0;
      end else if (CALL && RET) begin
        if (!empty) begin
          wr_en  = 1'b1;
          wr_idx = tos_q;
        end else begin
          do_push = 1'b1;
        end
      end else if (CALL) begin
        do_push = 1'b1;
      end else if (RET) begin
        if (!empty) begin
          tos_d   = tos_q - 1'b1;
          count_d = count_q - 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
    end

    if (do_push) begin
      if (full) begin
        ovf_d = 1'b1;
`ifdef RAS_OVERWRITE_EN
        // The slot after tos is the oldest entry when full; count stays at depth.
        wr_en  = 1'b1;
        wr_idx = tos_q + 1'b1;
        tos_d  = tos_q + 1'b1;
`endif
      end else begin
        wr_en   = 1'b1;
        wr_idx  = tos_q + 1'b1;
        tos_d   = tos_q + 1'b1;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_en) stack_q[wr_idx] <= link;
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign RETURN      = !empty;
  assign RETURN_ADDR = RETURN ? stack_q[tos_q] : '0;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack at STACK_DEPTH=4: vector table plus reset and overflow sequences.
module tb_return_addr_stack;

  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CACHE_READY;
  logic          CACHE_READY_DATA;
  logic          CALL;
  logic [AW-1:0] CALL_PC;
  logic          RET;
  logic          FLUSH;
  logic          RETURN;
  logic [AW-1:0] RETURN_ADDR;
  logic          OVERFLOW;
  logic          UNDERFLOW;

  return_addr_stack #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .CACHE_READY      (CACHE_READY),
    .CACHE_READY_DATA (CACHE_READY_DATA),
    .CALL             (CALL),
    .CALL_PC          (CALL_PC),
    .RET              (RET),
    .FLUSH            (FLUSH),
    .RETURN           (RETURN),
    .RETURN_ADDR      (RETURN_ADDR),
    .OVERFLOW         (OVERFLOW),
    .UNDERFLOW        (UNDERFLOW)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  typedef struct {
    logic          call;
    logic          ret;
    logic          flush;
    logic          rdy;
    logic          rdyd;
    logic [AW-1:0] pc;
    logic          exp_ret;
    logic [AW-1:0] exp_addr;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  vec_t          vecs[$];
  logic [AW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ret, input logic [AW-1:0] e_addr,
                           input logic e_ovf, input logic e_unf);
    check({tag, "_return"}, AW'(RETURN), AW'(e_ret));
    check({tag, "_addr"}, RETURN_ADDR, e_addr);
    check({tag, "_ovf"}, AW'(OVERFLOW), AW'(e_ovf));
    check({tag, "_unf"}, AW'(UNDERFLOW), AW'(e_unf));
  endtask

  // Driver tasks
  task automatic drive(input logic call, input logic ret, input logic flush,
                       input logic rdy, input logic rdyd, input logic [AW-1:0] pc);
    CALL = call; RET = ret; FLUSH = flush;
    CACHE_READY = rdy; CACHE_READY_DATA = rdyd; CALL_PC = pc;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic call, input logic ret, input logic flush, input logic rdy,
                     input logic rdyd, input logic [AW-1:0] pc, input logic e_ret,
                     input logic [AW-1:0] e_addr, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.call = call; v.ret = ret; v.flush = flush; v.rdy = rdy; v.rdyd = rdyd; v.pc = pc;
    v.exp_ret = e_ret; v.exp_addr = e_addr; v.exp_ovf = e_ovf; v.exp_unf = e_unf;
    vecs.push_back(v);
  endtask

  initial begin
    //   call ret flush rdy rdyd pc              ret addr           ovf unf
    add(1, 0, 0, 1, 1, 32'h0000_0100, 1, 32'h0000_0104, 0, 0);
    add(1, 0, 0, 1, 1, 32'h0000_0200, 1, 32'h0000_0204, 0, 0);
    add(1, 0, 0, 1, 1, 32'h0000_0300, 1, 32'h0000_0304, 0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         1, 32'h0000_0204, 0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         1, 32'h0000_0104, 0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         0, 32'h0,         0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         0, 32'h0,         0, 1);
    add(0, 0, 0, 1, 1, 32'h0,         0, 32'h0,         0, 0);
    add(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'h0000_0000, 0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         0, 32'h0,         0, 0);
    add(1, 0, 0, 1, 1, 32'h0000_0100, 1, 32'h0000_0104, 0, 0);
    add(1, 1, 0, 1, 1, 32'h0000_0800, 1, 32'h0000_0804, 0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         0, 32'h0,         0, 0);
    add(1, 1, 0, 1, 1, 32'h0000_0900, 1, 32'h0000_0904, 0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         0, 32'h0,         0, 0);
    add(1, 0, 0, 1, 1, 32'h0000_0010, 1, 32'h0000_0014, 0, 0);
    add(1, 0, 0, 1, 1, 32'h0000_0020, 1, 32'h0000_0024, 0, 0);
    add(1, 0, 1, 1, 1, 32'h0000_0030, 0, 32'h0,         0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         0, 32'h0,         0, 1);
    add(1, 0, 0, 1, 0, 32'h0000_0040, 0, 32'h0,         0, 0);
    add(1, 0, 0, 1, 0, 32'h0000_0040, 0, 32'h0,         0, 0);
    add(1, 0, 0, 1, 0, 32'h0000_0040, 0, 32'h0,         0, 0);
    add(1, 0, 0, 1, 1, 32'h0000_0040, 1, 32'h0000_0044, 0, 0);
    add(0, 1, 0, 1, 1, 32'h0,         0, 32'h0,         0, 0);
    add(1, 0, 0, 0, 1, 32'h0000_0060, 0, 32'h0,         0, 0);
    add(0, 1, 0, 0, 1, 32'h0,         0, 32'h0,         0, 0);
    add(0, 1, 0, 1, 0, 32'h0,         0, 32'h0,         0, 0);

    RST = 1'b1;
    drive(0, 0, 0, 1, 1, '0);
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset", 0, '0, 0, 0);
    RST = 1'b0;

    // Asynchronous reset in the middle of a cycle while CALL is held
    drive(1, 0, 0, 1, 1, 32'h0000_0100);
    step();
    check_all("pre_rst_push", 1, 32'h0000_0104, 0, 0);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_return", AW'(RETURN), '0);
    check("async_rst_addr", RETURN_ADDR, '0);
    step();
    RST = 1'b0;
    drive(0, 1, 0, 1, 1, '0);
    step();
    check_all("post_rst_pop", 0, '0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].call, vecs[i].ret, vecs[i].flush, vecs[i].rdy, vecs[i].rdyd, vecs[i].pc);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_ret, vecs[i].exp_addr,
                vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    // Overflow: fill to depth, then one extra push
    for (int k = 1; k <= DEPTH; k++) begin
      drive(1, 0, 0, 1, 1, AW'(k * 16));
      step();
      check_all($sformatf("fill%0d", k), 1, AW'(k * 16 + 4), 0, 0);
    end
    drive(1, 0, 0, 1, 1, 32'h0000_0050);
    step();
`ifdef RAS_OVERWRITE_EN
    check_all("ovf_push", 1, 32'h0000_0054, 1, 0);
    exp_q = '{32'h54, 32'h44, 32'h34, 32'h24};
`else
    check_all("ovf_push", 1, 32'h0000_0044, 1, 0);
    exp_q = '{32'h44, 32'h34, 32'h24, 32'h14};
`endif
    drive(0, 0, 0, 1, 1, '0);
    step();
    check("ovf_one_cycle", AW'(OVERFLOW), '0);

    // Scoreboard drain: top before each pop must match the expected queue
    for (int k = 0; k < DEPTH; k++) begin
      logic [AW-1:0] exp_top;
      exp_top = exp_q.pop_front();
      check($sformatf("drain%0d_addr", k), RETURN_ADDR, exp_top);
      drive(0, 1, 0, 1, 1, '0);
      step();
    end
    check_all("drained", 0, '0, 0, 0);

    drive(0, 0, 0, 1, 1, '0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
